// File: rtl/scan_doubler_if.sv
// Video bus between the palette stage, the scan doubler and the display side.
// Native-rate pixel inputs plus the doubled-rate output pixel and syncs.
interface scan_doubler_if;
    logic       h_half;
    logic       in_hsync;
    logic       in_vsync;
    logic [2:0] in_r;
    logic [2:0] in_g;
    logic [1:0] in_b;
    logic       in_valid;
    logic [2:0] out_r;
    logic [2:0] out_g;
    logic [1:0] out_b;
    logic       out_valid;
    logic       out_hsync;
    logic       out_vsync;

    modport master (
        output h_half, in_hsync, in_vsync, in_r, in_g, in_b, in_valid,
        input  out_r, out_g, out_b, out_valid, out_hsync, out_vsync
    );

    modport slave (
        input  h_half, in_hsync, in_vsync, in_r, in_g, in_b, in_valid,
        output out_r, out_g, out_b, out_valid, out_hsync, out_vsync
    );
endinterface

// File: rtl/scan_doubler.sv
// Line doubler: ping-pong line buffers, each native line replayed twice at full clk rate.
// Optional SCAN_DOUBLER_SCANLINE_EN dims the second copy of every line (each component >>1).
module scan_doubler #(
    parameter int H_ACTIVE    = 256,
    parameter int H_TOTAL     = 384,
    parameter int HSYNC_START = 300,
    parameter int HSYNC_LEN   = 46
) (
    input  logic          clk,
    input  logic          rst_n,
    scan_doubler_if.slave vid
);
    localparam int AW = $clog2(H_ACTIVE);
    localparam int WW = AW + 1;
    localparam int RW = $clog2(H_TOTAL);

    localparam logic [WW-1:0] WR_MAX  = WW'(H_ACTIVE);
    localparam logic [RW-1:0] RD_ACT  = RW'(H_ACTIVE);
    localparam logic [RW-1:0] RD_LAST = RW'(H_TOTAL - 1);
    localparam logic [RW-1:0] HS_BEG  = RW'(HSYNC_START);
    localparam logic [RW-1:0] HS_END  = RW'(HSYNC_START + HSYNC_LEN);

    // {valid, r, g, b}; upper address bit selects the bank
    logic [8:0] mem [0:2*H_ACTIVE-1];

    logic [WW-1:0] wr_x_q, wr_x_d;
    logic          wsel_q, wsel_d;
    logic          seen_q, seen_d;
    logic          primed_q, primed_d;
    logic [RW-1:0] rd_x_q, rd_x_d;
    logic          rd_line_q, rd_line_d;

    logic          we;
    logic [AW:0]   waddr;
    logic [8:0]    wdata;
    logic          strobe;

    // stage 1: RAM read plus the flags that travel with it
    logic [8:0]    rd_data_q;
    logic          vis1_q, hs1_q, vs1_q, line1_q;
    logic          vs1_d;

    // stage 2: output registers
    logic [7:0]    out_pix_q, out_pix_d;
    logic          out_vld_q, out_vld_d;
    logic          out_hs_q, out_vs_q;
    logic [7:0]    pix;

    assign strobe = ~vid.h_half;
    assign wdata  = {vid.in_valid, vid.in_r, vid.in_g, vid.in_b};

    always_comb begin
        wr_x_d   = wr_x_q;
        wsel_d   = wsel_q;
        seen_d   = seen_q;
        primed_d = primed_q;
        we       = 1'b0;
        waddr    = {wsel_q, wr_x_q[AW-1:0]};
        if (vid.in_hsync) begin
            // a sample coinciding with hsync is pixel 0 of the new line
            wsel_d   = ~wsel_q;
            seen_d   = 1'b1;
            primed_d = primed_q | seen_q;
            we       = strobe;
            waddr    = {~wsel_q, {AW{1'b0}}};
            wr_x_d   = strobe ? WW'(1) : '0;
        end else if (strobe && (wr_x_q < WR_MAX)) begin
            we     = 1'b1;
            wr_x_d = wr_x_q + WW'(1);
        end
    end

    always_comb begin
        rd_x_d    = rd_x_q + RW'(1);
        rd_line_d = rd_line_q;
        if (vid.in_hsync) begin
            rd_x_d    = '0;
            rd_line_d = 1'b0;
        end else if (rd_x_q == RD_LAST) begin
            rd_x_d    = '0;
            rd_line_d = ~rd_line_q;
        end
    end

    assign vs1_d = (rd_x_q == '0) ? vid.in_vsync : vs1_q;

    always_comb begin
        pix = rd_data_q[7:0];
`ifdef SCAN_DOUBLER_SCANLINE_EN
        if (line1_q)
            pix = {1'b0, pix[7:6], 1'b0, pix[4:3], 1'b0, pix[1]};
`endif
        out_vld_d = rd_data_q[8] & vis1_q;
        out_pix_d = out_vld_d ? pix : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_x_q    <= '0;
            wsel_q    <= 1'b0;
            seen_q    <= 1'b0;
            primed_q  <= 1'b0;
            rd_x_q    <= '0;
            rd_line_q <= 1'b0;
            rd_data_q <= '0;
            vis1_q    <= 1'b0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            line1_q   <= 1'b0;
            out_pix_q <= '0;
            out_vld_q <= 1'b0;
            out_hs_q  <= 1'b0;
            out_vs_q  <= 1'b0;
        end else begin
            wr_x_q    <= wr_x_d;
            wsel_q    <= wsel_d;
            seen_q    <= seen_d;
            primed_q  <= primed_d;
            rd_x_q    <= rd_x_d;
            rd_line_q <= rd_line_d;
            rd_data_q <= mem[{~wsel_q, rd_x_q[AW-1:0]}];
            vis1_q    <= (rd_x_q < RD_ACT) & primed_q;
            hs1_q     <= (rd_x_q >= HS_BEG) & (rd_x_q < HS_END);
            vs1_q     <= vs1_d;
            line1_q   <= rd_line_q;
            out_pix_q <= out_pix_d;
            out_vld_q <= out_vld_d;
            out_hs_q  <= hs1_q;
            out_vs_q  <= vs1_q;
        end
    end

    assign vid.out_r     = out_pix_q[7:5];
    assign vid.out_g     = out_pix_q[4:2];
    assign vid.out_b     = out_pix_q[1:0];
    assign vid.out_valid = out_vld_q;
    assign vid.out_hsync = out_hs_q;
    assign vid.out_vsync = out_vs_q;
endmodule
